bram3_line_flow_ctrl: RTL and testbench

Line-buffer flow controller between the processing core (writer) and the video output stage (reader) of the 128x128x3 output buffer BRAM3. It sequences BRAM3 port A writes and port B reads as a circular buffer of 384-bit lines. It aligns the buffer to the writer's frame start and supplies full/empty/level status to both sides. Underrun and frame-sync errors are detected and recovered by flushing and re-synchronising to the next frame.

---
 rtl/bram3_line_flow_ctrl.sv | 139 +++++++++++++
 tb/tb_bram3_line_flow_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram3_line_flow_ctrl.sv
// Circular line-buffer controller for BRAM3: port A write sequencing, port B read
// sequencing, frame-start alignment, fill/run gating and error flush/re-sync.
module bram3_line_flow_ctrl #(
    parameter int ADDR_W      = 7,
    parameter int DEPTH       = 128,
    parameter int FRAME_LINES = 128,
    parameter int START_LEVEL = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic              wr_vld_i,
    input  logic              wr_sof_i,
    input  logic [383:0]      wr_data_i,
    output logic              wr_rdy_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic [383:0]      dina_o,
    output logic              wea_o,
    input  logic              rd_req_i,
    output logic [ADDR_W-1:0] addrb_o,
    output logic              rd_vld_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              underrun_o,
    output logic              sof_err_o,
    input  logic              clear_i
);
    localparam int LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   START_C   = (ADDR_W+1)'(START_LEVEL);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);

    typedef enum logic [1:0] {WAIT_SOF, FILL, RUN, FLUSH} state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  wr_ptr_q, rd_ptr_q, addra_q, addrb_q;
    logic [ADDR_W:0]    count_q, count_d;
    logic [LINE_W-1:0]  wr_line_q;
    logic [383:0]       dina_q;
    logic               wea_q, rd_pend_q, rd_vld_q, full_q, empty_q;
    logic               underrun_q, sof_err_q;
    logic               push, pop, store, sof_bad, underrun_ev, go_flush;

    assign wr_rdy_o    = rst_n_i & enable_i & (state_q != FLUSH) & (count_q < DEPTH_C);
    assign push        = wr_vld_i & wr_rdy_o;
    assign sof_bad     = (state_q == RUN) & push & wr_sof_i & (wr_line_q != '0);
    assign underrun_ev = (state_q == RUN) & enable_i & rd_req_i & (count_q == '0);
    assign pop         = (state_q == RUN) & enable_i & rd_req_i & (count_q != '0);
    assign go_flush    = ((state_q == FILL) | (state_q == RUN)) & (~enable_i | sof_bad | underrun_ev);

    always_comb begin
        store = 1'b0;
        case (state_q)
            WAIT_SOF: store = push & wr_sof_i;
            FILL:     store = push;
            RUN:      store = push & ~sof_bad & ~underrun_ev;
            default:  store = 1'b0;
        endcase
    end

    assign count_d = count_q + {{ADDR_W{1'b0}}, store} - {{ADDR_W{1'b0}}, pop};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= WAIT_SOF;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_line_q  <= '0;
            addra_q    <= '0;
            dina_q     <= '0;
            wea_q      <= 1'b0;
            addrb_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            underrun_q <= 1'b0;
            sof_err_q  <= 1'b0;
        end else begin
            wea_q <= store;
            if (store) begin
                addra_q <= wr_ptr_q;
                dina_q  <= wr_data_i;
            end
            if (pop) begin
                addrb_q <= rd_ptr_q;
            end
            // BRAM port B has one cycle of read latency after the address register
            rd_pend_q  <= pop;
            rd_vld_q   <= rd_pend_q;
            underrun_q <= underrun_ev | (underrun_q & ~clear_i);
            sof_err_q  <= sof_bad | (sof_err_q & ~clear_i);

            if (go_flush) begin
                state_q   <= FLUSH;
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                count_q   <= '0;
                wr_line_q <= '0;
                rd_pend_q <= 1'b0;
                rd_vld_q  <= 1'b0;
                full_q    <= 1'b0;
                empty_q   <= 1'b1;
            end else begin
                if (store) begin
                    wr_ptr_q  <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
                    wr_line_q <= (wr_line_q == LINE_LAST) ? '0 : wr_line_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
                end
                count_q <= count_d;
                full_q  <= (count_d == DEPTH_C);
                empty_q <= (count_d == '0);
                case (state_q)
                    WAIT_SOF: if (store) state_q <= (START_LEVEL <= 1) ? RUN : FILL;
                    FILL:     if (count_d >= START_C) state_q <= RUN;
                    RUN:      state_q <= RUN;
                    FLUSH:    state_q <= WAIT_SOF;
                    default:  state_q <= WAIT_SOF;
                endcase
            end
        end
    end

    assign addra_o    = addra_q;
    assign dina_o     = dina_q;
    assign wea_o      = wea_q;
    assign addrb_o    = addrb_q;
    assign rd_vld_o   = rd_vld_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = count_q;
    assign underrun_o = underrun_q;
    assign sof_err_o  = sof_err_q;
endmodule

// File: tb/tb_bram3_line_flow_ctrl.sv
// Directed bench for bram3_line_flow_ctrl: reset, SOF alignment, full/wrap,
// simultaneous push/pop, underrun, SOF error and enable drop.
module tb_bram3_line_flow_ctrl;
    logic         clk = 1'b0;
    logic         rst_n, enable, wr_vld, wr_sof, rd_req, clear;
    logic [383:0] wr_data;
    logic         wr_rdy, wea, rd_vld, full, empty, underrun, sof_err;
    logic [6:0]   addra, addrb;
    logic [383:0] dina;
    logic [7:0]   level;

    int n_checks = 0;
    int n_errors = 0;

    bram3_line_flow_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable),
        .wr_vld_i(wr_vld), .wr_sof_i(wr_sof), .wr_data_i(wr_data), .wr_rdy_o(wr_rdy),
        .addra_o(addra), .dina_o(dina), .wea_o(wea),
        .rd_req_i(rd_req), .addrb_o(addrb), .rd_vld_o(rd_vld),
        .full_o(full), .empty_o(empty), .level_o(level),
        .underrun_o(underrun), .sof_err_o(sof_err), .clear_i(clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [63:0] pattern(input int n);
        return 64'hA5A5_0000_0000_0000 | 64'(n);
    endfunction

    task automatic push(input logic sof, input int tag, input int exp_addr, input int exp_level);
        wr_vld  = 1'b1;
        wr_sof  = sof;
        wr_data = {6{pattern(tag)}};
        cyc();
        check("push_wea", 64'(wea), 64'd1);
        check("push_addra", 64'(addra), 64'(exp_addr));
        check("push_dina_lo", dina[63:0], pattern(tag));
        check("push_dina_hi", dina[383:320], pattern(tag));
        check("push_level", 64'(level), 64'(exp_level));
        wr_vld = 1'b0;
        wr_sof = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; wr_vld = 1'b1; wr_sof = 1'b1;
        rd_req = 1'b0; clear = 1'b0; wr_data = '0;

        // Reset held 3 cycles with a line offered
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_wr_rdy", 64'(wr_rdy), 64'd0);
            check("rst_wea", 64'(wea), 64'd0);
            check("rst_empty", 64'(empty), 64'd1);
            check("rst_level", 64'(level), 64'd0);
            check("rst_full", 64'(full), 64'd0);
            check("rst_flags", 64'({underrun, sof_err, rd_vld}), 64'd0);
            check("rst_addr", 64'({addra, addrb}), 64'd0);
        end
        rst_n = 1'b1; wr_vld = 1'b0; wr_sof = 1'b0;
        $display("reset phase done");

        // SOF alignment: lines without sof dropped in WAIT_SOF
        for (int i = 0; i < 3; i++) begin
            wr_vld = 1'b1; wr_sof = 1'b0; wr_data = {6{pattern(100 + i)}};
            cyc();
            check("drop_wea", 64'(wea), 64'd0);
            check("drop_level", 64'(level), 64'd0);
        end
        wr_vld = 1'b0;
        for (int k = 0; k < 3; k++) push(k == 0, 200 + k, k, k + 1);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        check("fill_rdreq_level", 64'(level), 64'd3);
        check("wea_single_pulse", 64'(wea), 64'd0);
        cyc();
        check("fill_rdreq_vld", 64'(rd_vld), 64'd0);
        check("fill_no_underrun", 64'(underrun), 64'd0);
        push(1'b0, 203, 3, 4);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        check("run_pop_addrb", 64'(addrb), 64'd0);
        check("run_pop_level", 64'(level), 64'd3);
        check("run_pop_vld_early", 64'(rd_vld), 64'd0);
        cyc();
        check("run_pop_vld", 64'(rd_vld), 64'd1);
        cyc();
        check("run_vld_pulse", 64'(rd_vld), 64'd0);
        $display("sof alignment phase done");

        // Full and wrap
        do_reset();
        for (int i = 0; i < 128; i++) begin
            if (i == 127) check("not_full_127", 64'(full), 64'd0);
            push(i == 0, i, i, i + 1);
        end
        check("full_flag", 64'(full), 64'd1);
        wr_vld = 1'b1; wr_sof = 1'b0;
        #1;
        check("full_wr_rdy", 64'(wr_rdy), 64'd0);
        cyc();
        check("full_stall_wea", 64'(wea), 64'd0);
        check("full_stall_level", 64'(level), 64'd128);
        wr_vld = 1'b0; rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        check("full_pop_addrb", 64'(addrb), 64'd0);
        check("full_pop_level", 64'(level), 64'd127);
        check("full_pop_full", 64'(full), 64'd0);
        push(1'b1, 500, 0, 128);
        check("wrap_rd_vld", 64'(rd_vld), 64'd1);
        check("wrap_sof_ok", 64'(sof_err), 64'd0);
        $display("full/wrap phase done");

        // Simultaneous push/pop at level 10
        do_reset();
        for (int i = 0; i < 10; i++) push(i == 0, 300 + i, i, i + 1);
        for (int i = 0; i < 20; i++) begin
            wr_vld = 1'b1; wr_sof = 1'b0; rd_req = 1'b1; wr_data = {6{pattern(400 + i)}};
            cyc();
            check("pp_level", 64'(level), 64'd10);
            check("pp_addra", 64'(addra), 64'(10 + i));
            check("pp_addrb", 64'(addrb), 64'(i));
            check("pp_wea", 64'(wea), 64'd1);
            if (i >= 1) check("pp_rd_vld", 64'(rd_vld), 64'd1);
        end
        wr_vld = 1'b0; rd_req = 1'b0;
        $display("push/pop phase done");

        // Underrun: drain to level 1, pop it, then request again
        rd_req = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        rd_req = 1'b0;
        check("drain_level", 64'(level), 64'd1);
        cyc(); cyc();
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        check("last_pop_addrb", 64'(addrb), 64'd29);
        check("last_pop_empty", 64'(empty), 64'd1);
        cyc();
        check("last_pop_vld", 64'(rd_vld), 64'd1);
        check("no_underrun_yet", 64'(underrun), 64'd0);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        check("underrun_set", 64'(underrun), 64'd1);
        check("underrun_level", 64'(level), 64'd0);
        check("underrun_vld", 64'(rd_vld), 64'd0);
        check("flush_wr_rdy", 64'(wr_rdy), 64'd0);
        cyc();
        check("resync_wr_rdy", 64'(wr_rdy), 64'd1);
        check("underrun_sticky", 64'(underrun), 64'd1);
        wr_vld = 1'b1; wr_sof = 1'b0;
        cyc();
        wr_vld = 1'b0;
        check("resync_drop_wea", 64'(wea), 64'd0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("underrun_clear", 64'(underrun), 64'd0);
        $display("underrun phase done");

        // SOF error on frame line 5, with clear asserted in the same cycle
        for (int i = 0; i < 5; i++) push(i == 0, 600 + i, i, i + 1);
        wr_vld = 1'b1; wr_sof = 1'b1; clear = 1'b1; wr_data = {6{pattern(605)}};
        cyc();
        wr_vld = 1'b0; wr_sof = 1'b0; clear = 1'b0;
        check("soferr_set", 64'(sof_err), 64'd1);
        check("soferr_wea", 64'(wea), 64'd0);
        check("soferr_level", 64'(level), 64'd0);
        check("soferr_empty", 64'(empty), 64'd1);
        check("soferr_flush_rdy", 64'(wr_rdy), 64'd0);
        cyc();
        check("soferr_resync_rdy", 64'(wr_rdy), 64'd1);
        check("soferr_sticky", 64'(sof_err), 64'd1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("soferr_clear", 64'(sof_err), 64'd0);
        $display("sof error phase done");

        // Enable drop mid-RUN
        for (int i = 0; i < 6; i++) push(i == 0, 700 + i, i, i + 1);
        enable = 1'b0;
        #1;
        check("en_low_wr_rdy", 64'(wr_rdy), 64'd0);
        cyc();
        check("en_low_level", 64'(level), 64'd0);
        check("en_low_empty", 64'(empty), 64'd1);
        cyc();
        check("en_low_wr_rdy2", 64'(wr_rdy), 64'd0);
        check("en_low_level2", 64'(level), 64'd0);
        enable = 1'b1;
        push(1'b1, 800, 0, 1);
        $display("enable drop phase done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
